pipeline_issue_unit: RTL and testbench
======================================

// Module: pipeline_issue_unit
// PURPOSE
//  Producer side of the 3-stage pipeline's InstrIn port: buffers incoming instructions and issues
//  one per clk, inserting NOP bubbles so no instruction reads a register still in flight.
//  The pipeline has no forwarding and the regfile has no write-through.
//  Sits between instruction source (loader/testbench/fetch) and pipeline InstrIn.
// PARAMETERS
//  FIFO_DEPTH   4   instruction buffer entries (power of 2, >=2)
//  HAZARD_DEPTH 2   issued slots tracked for RAW hazards (fixed by pipeline timing, do not change)
//  CNT_W        16  width of saturating statistics counters
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   source presents in_instr
//  in_instr   in   32  instruction, pipeline encoding
//  in_ready   out  1   buffer can accept; transfer when in_valid & in_ready
//  flush      in   1   sync: discard buffered, not-yet-issued instructions
//  InstrOut   out  32  registered instruction to pipeline InstrIn
//  issued     out  1   registered: InstrOut holds a real instruction (0 = NOP)
//  busy       out  1   FIFO non-empty or any scoreboard slot valid
//  stall_cnt  out  CNT_W  bubbles inserted due to hazard (FIFO non-empty), saturating
//  issue_cnt  out  CNT_W  real instructions issued, saturating
// BEHAVIOUR
//  Encoding: [31:29] ALUOp, [28] DataSrc, [27] WriteEnable, [26:22] WriteSel,
//   [21:17] ReadSel1, [16:12] ReadSel2, [15:0] Imm (overlaps ReadSel2 when DataSrc=1).
//  NOP = 32'h0000_0000 (WriteEnable=0, no side effect).
//  Reset: InstrOut=NOP, issued=0, FIFO empty, scoreboard invalid, counters 0, in_ready=1.
//  in_ready = !full (combinational). No push bypass when full, even with a same-cycle pop.
//  Scoreboard: SB[0] = instruction on InstrOut now, SB[1] = previous.
//   Each entry = {valid = WriteEnable, WriteSel}. Shifts every clk; a NOP shifts in as invalid.
//  Hazard for FIFO head H:
//   (any valid SB[k].WriteSel == H.ReadSel1) or (H.DataSrc==0 and match on H.ReadSel2).
//   All 32 registers are tracked; r0 is not special.
//  Timing: an instruction issued at slot t commits its regfile write before the read of slot t+3.
//   Hence exactly 2 intervening slots are required.
//  Each clk:
//   - head present and no hazard -> InstrOut<=H, issued<=1, pop, issue_cnt++.
//   - head present with hazard -> InstrOut<=NOP, issued<=0, stall_cnt++.
//   - FIFO empty -> InstrOut<=NOP, issued<=0, no count.
//  Latency: a word accepted at edge e into an empty FIFO, with no hazard, appears on InstrOut at edge e+1.
//  Order is strictly preserved; an instruction is never issued twice or dropped (except by flush/rst).
//  flush: FIFO emptied at the edge. A pop that cycle still issues the head.
//   A push that cycle is discarded. Scoreboard is kept, since those instructions are in flight.
//  Counters hold at all-ones. rst mid-operation clears state immediately (async), including InstrOut.
// STRUCTURE
//  pipeline_pkg: field-position localparams, NOP constant, instr_t field-extract functions.
//  Sub-module issue_fifo (FIFO_DEPTH x 32, ptr+1-bit wrap, full/empty, flush).
//  Top: scoreboard shift register, hazard compare, output flops, counters.
// TESTING
//  1 Three independent ops (WS r1,r2,r3; RS r4/r5) pushed back-to-back
//    -> InstrOut I0,I1,I2 on consecutive edges; stall_cnt=0, issue_cnt=3.
//  2 I0 WE=1 WS=r3; I1 RS1=r3
//    -> InstrOut I0,NOP,NOP,I1; stall_cnt=2.
//  3 I0 WS=r3; I1 independent; I2 RS2=r3, DataSrc=0
//    -> I0,I1,NOP,I2; stall_cnt=1.
//  4 I0 WS=r3; I1 DataSrc=1, Imm=16'h3000 (bits[16:12]=r3)
//    -> no stall. Also I0 with WE=0 followed by a reader of r3 -> no stall.
//  5 Hold hazard (case 2) while pushing 6 words
//    -> in_ready low after FIFO fills with 4; every accepted word issued in order; none lost.
//  6 rst asserted mid-edge with 3 words queued
//    -> InstrOut=0 and issued=0 without waiting for clk; in_ready=1.
//    After release the first new push issues with no spurious stall.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Instruction field positions, NOP constant, scoreboard entry
//               type and field-extract helpers for the 3-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam int c_instr_w  = 32;
  localparam int c_reg_w    = 5;
  localparam int c_ds_bit   = 28;
  localparam int c_we_bit   = 27;
  localparam int c_ws_lsb   = 22;
  localparam int c_rs1_lsb  = 17;
  localparam int c_rs2_lsb  = 12;

  typedef logic [c_instr_w-1:0] instr_t;
  typedef logic [c_reg_w-1:0]   reg_idx_t;

  // NOP has WriteEnable clear, so it has no architectural side effect.
  localparam instr_t c_nop = 32'h0000_0000;

  // One in-flight write tracked for RAW detection.
  typedef struct packed {
    logic     valid;
    reg_idx_t ws;
  } sb_entry_t;

  function automatic logic instr_we(input instr_t i);
    return i[c_we_bit];
  endfunction

  function automatic logic instr_ds(input instr_t i);
    return i[c_ds_bit];
  endfunction

  function automatic reg_idx_t instr_ws(input instr_t i);
    return i[c_ws_lsb +: c_reg_w];
  endfunction

  function automatic reg_idx_t instr_rs1(input instr_t i);
    return i[c_rs1_lsb +: c_reg_w];
  endfunction

  function automatic reg_idx_t instr_rs2(input instr_t i);
    return i[c_rs2_lsb +: c_reg_w];
  endfunction

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/pipeline_issue_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : issue_fifo
// Description : DEPTH x 32 instruction buffer, pointer plus wrap bit for
//               full/empty, synchronous flush of all buffered entries.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  instr_t wdata,
  output instr_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int c_aw    = $clog2(DEPTH);
  localparam int c_ptr_w = c_aw + 1;

  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  instr_t             mem_q [DEPTH];
  logic               w_wr_en;
  logic               w_rd_en;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                   (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
  assign w_wr_en = push && !full;
  assign w_rd_en = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[c_aw-1:0]];

  // Pointer update; flush wins over push/pop and leaves the buffer empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_wr_en) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
      if (w_rd_en) rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[wr_ptr_q[c_aw-1:0]] <= wdata;
  end

endmodule : issue_fifo
`default_nettype wire

// File: rtl/pipeline_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_issue_unit
// Description : Buffers instructions and issues one per clock to the
//               pipeline, inserting NOP bubbles while a source register of
//               the head instruction is still being written by an in-flight
//               instruction (no forwarding, no regfile write-through).
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_issue_unit
  import pipeline_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int HAZARD_DEPTH = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  input  logic             flush,
  output logic [31:0]      InstrOut,
  output logic             issued,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt
);

  instr_t     w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_stall;
  logic       w_hazard;
  logic       w_sb_any;

  instr_t     instr_out_q, instr_out_d;
  logic       issued_q, issued_d;
  sb_entry_t  sb_q [HAZARD_DEPTH];
  sb_entry_t  sb_d [HAZARD_DEPTH];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

  // A push coinciding with flush is dropped along with the buffer contents.
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full && !flush;
  assign w_pop    = !w_empty && !w_hazard;
  assign w_stall  = !w_empty && w_hazard;

  issue_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (flush),
    .wdata (in_instr),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // RAW check of the head against every tracked in-flight write; with an
  // immediate operand the ReadSel2 bits are data, not a register index.
  always_comb begin
    w_hazard = 1'b0;
    w_sb_any = 1'b0;
    for (int k = 0; k < HAZARD_DEPTH; k++) begin
      w_sb_any = w_sb_any | sb_q[k].valid;
      if (sb_q[k].valid) begin
        if (sb_q[k].ws == instr_rs1(w_head)) w_hazard = 1'b1;
        if (!instr_ds(w_head) && (sb_q[k].ws == instr_rs2(w_head))) w_hazard = 1'b1;
      end
    end
  end

  // Next output slot, scoreboard shift and saturating statistics.
  always_comb begin
    instr_out_d = c_nop;
    issued_d    = 1'b0;
    stall_cnt_d = stall_cnt_q;
    issue_cnt_d = issue_cnt_q;
    sb_d[0]     = '0;
    for (int k = 1; k < HAZARD_DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    if (w_pop) begin
      instr_out_d   = w_head;
      issued_d      = 1'b1;
      sb_d[0].valid = instr_we(w_head);
      sb_d[0].ws    = instr_ws(w_head);
      if (issue_cnt_q != '1) issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end else if (w_stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Output, scoreboard and counter registers; reset forces a NOP at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_out_q <= c_nop;
      issued_q    <= 1'b0;
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
      for (int k = 0; k < HAZARD_DEPTH; k++) begin
        sb_q[k] <= '0;
      end
    end else begin
      instr_out_q <= instr_out_d;
      issued_q    <= issued_d;
      stall_cnt_q <= stall_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      for (int k = 0; k < HAZARD_DEPTH; k++) begin
        sb_q[k] <= sb_d[k];
      end
    end
  end

  assign InstrOut  = instr_out_q;
  assign issued    = issued_q;
  assign busy      = !w_empty || w_sb_any;
  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;

endmodule : pipeline_issue_unit
`default_nettype wire

// File: tb/tb_pipeline_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_issue_unit
// Description : Self-checking bench for pipeline_issue_unit: vector table of
//               short instruction streams with expected InstrOut sequences,
//               plus hand-written fill, flush and async-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_issue_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic [31:0] InstrOut;
  logic        issued;
  logic        busy;
  logic [15:0] stall_cnt;
  logic [15:0] issue_cnt;

  int checks;
  int errors;

  logic [31:0] exp_q [$];

  typedef struct {
    int              n_in;
    logic [2:0][31:0] ins;
    int              n_out;
    logic [3:0][31:0] outs;
    int              stalls;
    int              issues;
  } vec_t;

  vec_t vecs [6];

  pipeline_issue_unit #(
    .FIFO_DEPTH   (4),
    .HAZARD_DEPTH (2),
    .CNT_W        (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .InstrOut  (InstrOut),
    .issued    (issued),
    .busy      (busy),
    .stall_cnt (stall_cnt),
    .issue_cnt (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build an instruction from its fields: ALUOp, DataSrc, WE, WS, RS1, RS2.
  function automatic logic [31:0] mk(input int alu, input int ds, input int we,
                                     input int ws, input int rs1, input int rs2);
    logic [31:0] r;
    r        = 32'h0;
    r[31:29] = alu[2:0];
    r[28]    = ds[0];
    r[27]    = we[0];
    r[26:22] = ws[4:0];
    r[21:17] = rs1[4:0];
    r[16:12] = rs2[4:0];
    return r;
  endfunction

  function automatic vec_t mkv(input int ni, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input int no, input logic [31:0] p,
                               input logic [31:0] q, input logic [31:0] r, input logic [31:0] s,
                               input int st, input int is);
    vec_t v;
    v.n_in    = ni;
    v.ins[0]  = a;
    v.ins[1]  = b;
    v.ins[2]  = c;
    v.n_out   = no;
    v.outs[0] = p;
    v.outs[1] = q;
    v.outs[2] = r;
    v.outs[3] = s;
    v.stalls  = st;
    v.issues  = is;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the unit to go idle so the next stream starts clean.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " drain busy"}, {31'b0, busy}, 32'h0);
  endtask

  // Push a vector back-to-back; outputs are due from the second edge on.
  task automatic run_vec(input vec_t v, input int idx);
    int s0, i0;
    logic [31:0] e;
    string nm;
    nm = $sformatf("vec%0d", idx);
    s0 = int'(stall_cnt);
    i0 = int'(issue_cnt);
    for (int k = 0; k < v.n_out; k++) exp_q.push_back(v.outs[k]);
    for (int c = 0; c < v.n_out + 2; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        e = exp_q.pop_front();
        chk({nm, " InstrOut"}, InstrOut, e);
        chk({nm, " issued"}, {31'b0, issued}, {31'b0, (e != 32'h0)});
      end
      if (c < v.n_in) begin
        in_valid = 1'b1;
        in_instr = v.ins[c];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk({nm, " stall delta"}, 32'(int'(stall_cnt) - s0), 32'(v.stalls));
    chk({nm, " issue delta"}, 32'(int'(issue_cnt) - i0), 32'(v.issues));
    drain(nm);
  endtask

  logic [31:0] w5 [6];
  logic [31:0] ra, rb, rc, rd;

  initial begin
    int idx, got, s0, i0, nonissue;
    logic saw_full;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'h0;
    flush    = 1'b0;

    vecs[0] = mkv(3, mk(1,0,1,1,4,5), mk(1,0,1,2,4,5), mk(1,0,1,3,4,5),
                  3, mk(1,0,1,1,4,5), mk(1,0,1,2,4,5), mk(1,0,1,3,4,5), 32'h0, 0, 3);
    vecs[1] = mkv(2, mk(1,0,1,3,4,5), mk(2,0,1,6,3,5), 32'h0,
                  4, mk(1,0,1,3,4,5), 32'h0, 32'h0, mk(2,0,1,6,3,5), 2, 2);
    vecs[2] = mkv(3, mk(1,0,1,3,4,5), mk(1,0,1,7,4,5), mk(2,0,1,8,4,3),
                  4, mk(1,0,1,3,4,5), mk(1,0,1,7,4,5), 32'h0, mk(2,0,1,8,4,3), 1, 3);
    vecs[3] = mkv(2, mk(1,0,1,3,4,5), mk(3,1,1,9,4,3), 32'h0,
                  2, mk(1,0,1,3,4,5), mk(3,1,1,9,4,3), 32'h0, 32'h0, 0, 2);
    vecs[4] = mkv(2, mk(1,0,0,3,4,5), mk(2,0,1,10,3,3), 32'h0,
                  2, mk(1,0,0,3,4,5), mk(2,0,1,10,3,3), 32'h0, 32'h0, 0, 2);
    vecs[5] = mkv(2, mk(1,0,1,0,4,5), mk(1,0,1,11,0,5), 32'h0,
                  4, mk(1,0,1,0,4,5), 32'h0, 32'h0, mk(1,0,1,11,0,5), 2, 2);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst InstrOut", InstrOut, 32'h0);
    chk("rst issued", {31'b0, issued}, 32'h0);
    chk("rst in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst busy", {31'b0, busy}, 32'h0);
    chk("rst stall_cnt", {16'b0, stall_cnt}, 32'h0);
    chk("rst issue_cnt", {16'b0, issue_cnt}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

    // Fill: dependent chain keeps the head stalled until the buffer is full.
    w5[0] = mk(1,0,1,3,4,5);
    w5[1] = mk(2,0,1,6,3,5);
    w5[2] = mk(2,0,1,7,6,5);
    w5[3] = mk(1,0,1,12,4,5);
    w5[4] = mk(1,0,1,13,4,5);
    w5[5] = mk(1,0,1,14,4,5);
    idx = 0; got = 0; saw_full = 1'b0;
    s0 = int'(stall_cnt);
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      if (issued) begin
        if (exp_q.size() == 0) begin
          chk("fill unexpected issue", InstrOut, 32'h0);
        end else begin
          chk("fill order", InstrOut, exp_q.pop_front());
        end
        got++;
      end
      if (!in_ready) saw_full = 1'b1;
      if (idx < 6) begin
        in_valid = 1'b1;
        in_instr = w5[idx];
        if (in_ready) begin
          exp_q.push_back(w5[idx]);
          idx++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("fill issued count", 32'(got), 32'd6);
    chk("fill in_ready low seen", {31'b0, saw_full}, 32'h1);
    chk("fill leftover", 32'(exp_q.size()), 32'h0);
    chk("fill stall delta", 32'(int'(stall_cnt) - s0), 32'd4);
    exp_q.delete();
    drain("fill");

    // Flush while the head is stalled: buffered words and same-cycle push lost.
    ra = mk(1,0,1,3,4,5); rb = mk(2,0,1,6,3,5); rc = mk(1,0,1,15,4,5); rd = mk(1,0,1,16,4,5);
    i0 = int'(issue_cnt);
    @(negedge clk); in_valid = 1'b1; in_instr = ra;
    @(negedge clk); in_instr = rb;
    @(negedge clk); in_instr = rc;
    chk("flush A out", InstrOut, ra);
    @(negedge clk); in_instr = rd; flush = 1'b1;
    @(negedge clk); in_valid = 1'b0; flush = 1'b0;
    chk("flush busy after", {31'b0, busy}, 32'h0);
    nonissue = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (issued) nonissue++;
    end
    chk("flush no issue after", 32'(nonissue), 32'h0);
    chk("flush issue delta", 32'(int'(issue_cnt) - i0), 32'd1);

    // Flush in a cycle that also pops: head still issues, push is dropped.
    @(negedge clk); in_valid = 1'b1; in_instr = rc;
    @(negedge clk); in_instr = rd; flush = 1'b1;
    @(negedge clk); in_valid = 1'b0; flush = 1'b0;
    chk("flush-pop out", InstrOut, rc);
    @(negedge clk);
    chk("flush-pop next", {31'b0, issued}, 32'h0);
    drain("flush-pop");

    // Async reset with three words queued behind a stalled head.
    @(negedge clk); in_valid = 1'b1; in_instr = ra;
    @(negedge clk); in_instr = rb;
    @(negedge clk); in_instr = rc;
    @(negedge clk); in_instr = rd;
    @(negedge clk); in_valid = 1'b0;
    chk("pre-rst busy", {31'b0, busy}, 32'h1);
    chk("pre-rst in_ready", {31'b0, in_ready}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async rst InstrOut", InstrOut, 32'h0);
    chk("async rst issued", {31'b0, issued}, 32'h0);
    chk("async rst in_ready", {31'b0, in_ready}, 32'h1);
    chk("async rst busy", {31'b0, busy}, 32'h0);
    chk("async rst issue_cnt", {16'b0, issue_cnt}, 32'h0);
    @(negedge clk); rst = 1'b0;
    run_vec(mkv(1, mk(2,0,1,20,3,3), 32'h0, 32'h0, 1, mk(2,0,1,20,3,3),
                32'h0, 32'h0, 32'h0, 0, 1), 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_issue_unit
`default_nettype wire
